// File: rtl/ultrasonic_pkg.sv
// rtl/ultrasonic_pkg.sv - shared states, timing defaults and codes for the ultrasonic ranger scheduler
package ultrasonic_pkg;

    localparam int CLK_HZ = 100_000_000;

    // HC-SR04 timing: 10 us trigger, 30 ms echo window, 60 ms quiet time
    localparam int DEF_TRIG_CYCLES    = CLK_HZ / 100_000;
    localparam int DEF_TIMEOUT_CYCLES = (CLK_HZ / 1000) * 30;
    localparam int DEF_GUARD_CYCLES   = (CLK_HZ / 1000) * 60;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIGGER   = 3'd1;
    localparam logic [2:0] ST_WAIT_ECHO = 3'd2;
    localparam logic [2:0] ST_MEASURE   = 3'd3;
    localparam logic [2:0] ST_PUBLISH   = 3'd4;
    localparam logic [2:0] ST_GUARD     = 3'd5;

    // Timeout results report an all-ones count; users slice to their count width
    localparam int              MAX_CNT_W    = 32;
    localparam logic [MAX_CNT_W-1:0] TIMEOUT_CODE = '1;

endpackage

// File: rtl/ultrasonic_scheduler_rr_sensor_pick.sv
// rtl/ultrasonic_scheduler_rr_sensor_pick.sv - round-robin pick of the next enabled sensor after prev_sel
import ultrasonic_pkg::*;

module rr_sensor_pick #(
    parameter int NUM_SENSORS = 4,
    parameter int SEL_W       = $clog2(NUM_SENSORS)
) (
    input  logic [NUM_SENSORS-1:0] mask,       // 1 = candidate
    input  logic [SEL_W-1:0]       prev_sel,   // last selected index
    output logic [SEL_W-1:0]       next_sel,   // nearest set bit after prev_sel, wrapping
    output logic                   none_valid  // mask is empty
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        next_sel   = prev_sel;
        none_valid = ~|mask;
        idx        = '0;
        // Scan farthest-first so the nearest candidate is the last one written;
        // k == NUM_SENSORS lands on prev_sel itself for a single-bit mask.
        for (int k = NUM_SENSORS; k >= 1; k--) begin
            idx = SEL_W'((int'(prev_sel) + k) % NUM_SENSORS);
            if (mask[idx]) begin
                next_sel = idx;
            end
        end
    end

endmodule

// File: rtl/ultrasonic_scheduler.sv
// rtl/ultrasonic_scheduler.sv - time-multiplexed trigger/echo scheduler for HC-SR04-style rangers
import ultrasonic_pkg::*;

module ultrasonic_scheduler #(
    parameter int NUM_SENSORS    = 4,
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int CNT_W          = 24
) (
    input  logic                           clk,          // system clock
    input  logic                           reset,        // synchronous, active-high
    input  logic                           enable,       // run the scan loop
    input  logic [NUM_SENSORS-1:0]         sensor_mask,  // 1 = sensor included in the scan
    input  logic [NUM_SENSORS-1:0]         echo,         // raw asynchronous echo lines
    output logic [NUM_SENSORS-1:0]         trigger,      // one-hot trigger outputs
    output logic                           dist_valid,   // one-cycle result strobe
    output logic [$clog2(NUM_SENSORS)-1:0] dist_sensor,  // index of the measured sensor
    output logic [CNT_W-1:0]               dist_count,   // echo-high width in clk cycles
    output logic                           dist_timeout, // no echo, or echo too long
    output logic                           busy          // not idle
);

    localparam int SEL_W = $clog2(NUM_SENSORS);

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = TIMEOUT_CODE[CNT_W-1:0];

    logic [2:0]             state;
    logic [CNT_W-1:0]       timer;
    logic [CNT_W-1:0]       count;
    logic [SEL_W-1:0]       sel;
    logic [SEL_W-1:0]       pick_sel;
    logic                   pick_none;
    logic                   start_ok;
    logic                   echo_hit;
    logic [NUM_SENSORS-1:0] echo_meta;
    logic [NUM_SENSORS-1:0] echo_s;

    function automatic logic [NUM_SENSORS-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Two-flop synchronizer on every echo line; the 2-cycle delay is left uncompensated
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_meta <= '0;
            echo_s    <= '0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
        end
    end

    rr_sensor_pick #(
        .NUM_SENSORS (NUM_SENSORS),
        .SEL_W       (SEL_W)
    ) u_pick (
        .mask       (sensor_mask),
        .prev_sel   (sel),
        .next_sel   (pick_sel),
        .none_valid (pick_none)
    );

    assign start_ok = enable && !pick_none;
    assign echo_hit = echo_s[sel];
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            timer        <= '0;
            count        <= '0;
            // Parking on the top index makes the first pick the lowest enabled one
            sel          <= SEL_W'(NUM_SENSORS - 1);
            trigger      <= '0;
            dist_valid   <= 1'b0;
            dist_sensor  <= '0;
            dist_count   <= '0;
            dist_timeout <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        sel     <= pick_sel;
                        trigger <= onehot(pick_sel);
                        timer   <= '0;
                        state   <= ST_TRIGGER;
                    end
                end
                ST_TRIGGER: begin
                    if (timer == TRIG_LAST) begin
                        trigger <= '0;
                        timer   <= '0;
                        state   <= ST_WAIT_ECHO;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_WAIT_ECHO: begin
                    timer <= timer + 1'b1;
                    // Timeout is tested first so it wins over a coincident echo edge
                    if (timer == TIMEOUT_LAST) begin
                        dist_valid   <= 1'b1;
                        dist_sensor  <= sel;
                        dist_count   <= CNT_MAX;
                        dist_timeout <= 1'b1;
                        state        <= ST_PUBLISH;
                    end else if (echo_hit) begin
                        count <= CNT_W'(1);
                        state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    // timer keeps running from WAIT_ECHO, bounding the whole window
                    timer <= timer + 1'b1;
                    if (timer == TIMEOUT_LAST) begin
                        dist_valid   <= 1'b1;
                        dist_sensor  <= sel;
                        dist_count   <= CNT_MAX;
                        dist_timeout <= 1'b1;
                        state        <= ST_PUBLISH;
                    end else if (echo_hit) begin
                        if (count != CNT_MAX) begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        dist_valid   <= 1'b1;
                        dist_sensor  <= sel;
                        dist_count   <= count;
                        dist_timeout <= 1'b0;
                        state        <= ST_PUBLISH;
                    end
                end
                ST_PUBLISH: begin
                    timer <= '0;
                    state <= ST_GUARD;
                end
                ST_GUARD: begin
                    if (timer == GUARD_LAST) begin
                        timer <= '0;
                        if (start_ok) begin
                            sel     <= pick_sel;
                            trigger <= onehot(pick_sel);
                            state   <= ST_TRIGGER;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    trigger <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// tb/tb_ultrasonic_scheduler.sv - scoreboard bench for ultrasonic_scheduler
`timescale 1ns/1ps
module tb_ultrasonic_scheduler;

    localparam int NS    = 4;
    localparam int TRIG  = 4;
    localparam int TMO   = 200;
    localparam int GUARD = 10;
    localparam int CW    = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [NS-1:0] sensor_mask = '0;
    logic [NS-1:0] echo = '0;
    logic [NS-1:0] trigger;
    logic          dist_valid;
    logic [1:0]    dist_sensor;
    logic [CW-1:0] dist_count;
    logic          dist_timeout;
    logic          busy;

    ultrasonic_scheduler #(
        .NUM_SENSORS    (NS),
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TMO),
        .GUARD_CYCLES   (GUARD),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sensor_mask  (sensor_mask),
        .echo         (echo),
        .trigger      (trigger),
        .dist_valid   (dist_valid),
        .dist_sensor  (dist_sensor),
        .dist_count   (dist_count),
        .dist_timeout (dist_timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sensor;
        int count;
        int to;
        int lat;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int results = 0;
    int trig_rises = 0;
    int last_valid_cyc = 0;

    // kind: 0 = echo pulse of cfg_width after cfg_delay, 1 = no echo, 2 = echo stuck high
    int cfg_kind [NS];
    int cfg_delay[NS];
    int cfg_width[NS];

    logic [NS-1:0] mask_q = '0;
    logic          reset_q = 1'b1;

    always @(posedge clk) begin
        cyc++;
        mask_q  = sensor_mask;
        reset_q = reset;
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int next_pick(input logic [NS-1:0] m, input int last);
        int mi;
        mi = int'(m);
        for (int k = 1; k <= NS; k++) begin
            if (((mi >> ((last + k) % NS)) & 1) != 0) return (last + k) % NS;
        end
        return -1;
    endfunction

    // Monitor: predicts picks, issues echo responses, scores results
    initial begin : monitor
        int model_last, trig_len, fall_cyc, last_fall;
        int act, e_kind, e_wait, e_high;
        int pend_kind, pend_delay, pend_width;
        int hold_sensor, hold_count, hold_to;
        logic [NS-1:0] prev_trig;
        logic prev_valid;
        model_last = NS - 1; trig_len = 0; fall_cyc = 0; last_fall = -1000;
        act = -1; e_kind = 0; e_wait = 0; e_high = 0;
        pend_kind = 1; pend_delay = 0; pend_width = 0;
        hold_sensor = 0; hold_count = 0; hold_to = 0;
        prev_trig = '0; prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_q) begin
                sb.delete();
                model_last = NS - 1;
                prev_trig = '0;
                act = -1;
                echo = '0;
                hold_sensor = 0; hold_count = 0; hold_to = 0;
                last_fall = -1000;
            end else begin
                if (trigger != '0 && prev_trig == '0) begin
                    int s;
                    logic [NS-1:0] exp_vec;
                    exp_t e;
                    s = next_pick(mask_q, model_last);
                    trig_rises++;
                    exp_vec = (s < 0) ? '0 : (NS'(1) << s);
                    check("trig_pick", trigger, exp_vec);
                    check("trig_spacing", (cyc - last_fall) >= GUARD, 1);
                    if (s >= 0) begin
                        model_last = s;
                        pend_kind = cfg_kind[s]; pend_delay = cfg_delay[s]; pend_width = cfg_width[s];
                        e.sensor = s;
                        // echo_s sees the fall at cycle d+w+2 of the echo window
                        if (pend_kind == 0 && pend_delay + pend_width + 2 <= TMO - 2) begin
                            e.count = pend_width; e.to = 0; e.lat = pend_delay + pend_width + 3;
                        end else begin
                            e.count = (1 << CW) - 1; e.to = 1; e.lat = TMO;
                        end
                        sb.push_back(e);
                    end
                    trig_len = 0;
                end
                if (trigger != '0) begin
                    trig_len++;
                    check("trig_onehot", $countones(trigger), 1);
                end
                if (trigger == '0 && prev_trig != '0) begin
                    check("trig_len", trig_len, TRIG);
                    fall_cyc = cyc;
                    last_fall = cyc;
                    if (act >= 0) echo = echo & ~(NS'(1) << act);
                    act = model_last;
                    e_kind = pend_kind; e_wait = pend_delay; e_high = pend_width;
                end
                prev_trig = trigger;
                if (act >= 0) begin
                    case (e_kind)
                        0: begin
                            if (e_wait > 0) e_wait--;
                            else if (e_high > 0) begin echo = echo | (NS'(1) << act); e_high--; end
                            else begin echo = echo & ~(NS'(1) << act); act = -1; end
                        end
                        2: begin echo = echo | (NS'(1) << act); act = -1; end
                        default: begin echo = echo & ~(NS'(1) << act); act = -1; end
                    endcase
                end
            end
            if (dist_valid) begin
                check("valid_one_cycle", prev_valid, 0);
                check("result_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("res_sensor", dist_sensor, e.sensor);
                    check("res_count", dist_count, e.count);
                    check("res_timeout", dist_timeout, e.to);
                    check("res_latency", cyc - fall_cyc, e.lat);
                    hold_sensor = e.sensor; hold_count = e.count; hold_to = e.to;
                end
                results++;
                last_valid_cyc = cyc;
            end else begin
                check("hold_sensor", dist_sensor, hold_sensor);
                check("hold_count", dist_count, hold_count);
                check("hold_timeout", dist_timeout, hold_to);
            end
            prev_valid = dist_valid;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int target, budget;
        target = results + n;
        budget = n * 400 + 100;
        while (results < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("results_arrived", results >= target, 1);
    endtask

    task automatic wait_idle(output int at);
        int budget;
        budget = 400;
        do begin
            @(negedge clk);
            budget--;
        end while (busy && budget > 0);
        check("went_idle", busy, 0);
        at = cyc;
    endtask

    task automatic set_all(input int kind, input int d, input int w);
        for (int i = 0; i < NS; i++) begin
            cfg_kind[i] = kind; cfg_delay[i] = d; cfg_width[i] = w;
        end
    endtask

    initial begin : watchdog
        #700000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int at, r, budget;
        set_all(1, 0, 0);

        // reset state
        do_reset();
        check("rst_trigger", trigger, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", dist_valid, 0);
        check("rst_sensor", dist_sensor, 0);
        check("rst_count", dist_count, 0);
        check("rst_timeout", dist_timeout, 0);

        // basic measurement, single sensor re-selected
        set_all(0, 20, 50);
        sensor_mask = 4'b0001;
        enable = 1'b1;
        wait_results(2);
        enable = 1'b0;
        wait_idle(at);

        // round robin with gaps
        for (int i = 0; i < NS; i++) begin
            cfg_kind[i] = 0; cfg_delay[i] = 5; cfg_width[i] = 30 + 10 * i;
        end
        sensor_mask = 4'b1011;
        enable = 1'b1;
        wait_results(4);
        enable = 1'b0;
        wait_idle(at);

        // no echo, then echo-length boundary around the timeout
        do_reset();
        cfg_kind[2] = 1;
        sensor_mask = 4'b0100;
        enable = 1'b1;
        wait_results(1);
        sensor_mask = 4'b0001;
        cfg_kind[0] = 0; cfg_delay[0] = 0; cfg_width[0] = 196;
        wait_results(1);
        cfg_width[0] = 197;
        wait_results(1);
        enable = 1'b0;
        wait_idle(at);

        // echo stuck high on sensor 1
        do_reset();
        cfg_kind[0] = 0; cfg_delay[0] = 3; cfg_width[0] = 25;
        cfg_kind[1] = 2;
        sensor_mask = 4'b0011;
        enable = 1'b1;
        wait_results(3);
        enable = 1'b0;
        wait_idle(at);

        // enable dropped during MEASURE
        do_reset();
        cfg_kind[1] = 0; cfg_delay[1] = 2; cfg_width[1] = 80;
        sensor_mask = 4'b0010;
        enable = 1'b1;
        budget = 300;
        while (echo[1] == 1'b0 && budget > 0) begin @(negedge clk); budget--; end
        check("echo_started", echo[1], 1);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_results(1);
        wait_idle(at);
        check("guard_then_idle", at - last_valid_cyc, GUARD + 1);
        r = trig_rises;
        repeat (60) @(negedge clk);
        check("no_trigger_after_disable", trig_rises, r);
        sensor_mask = 4'b0000;
        enable = 1'b1;
        repeat (30) @(negedge clk);
        check("empty_mask_busy", busy, 0);
        check("empty_mask_no_trigger", trig_rises, r);

        // mask cleared during GUARD
        set_all(0, 4, 20);
        sensor_mask = 4'b0011;
        wait_results(1);
        sensor_mask = 4'b0000;
        wait_idle(at);
        check("mask0_guard_idle", at - last_valid_cyc, GUARD + 1);
        enable = 1'b0;

        // reset during TRIGGER
        do_reset();
        sensor_mask = 4'b1110;
        enable = 1'b1;
        wait_results(1);
        budget = 100;
        while (trigger == '0 && budget > 0) begin @(negedge clk); budget--; end
        check("second_trigger_seen", trigger, 4'b0100);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_trigger", trigger, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", dist_valid, 0);
        reset = 1'b0;
        wait_results(1);
        enable = 1'b0;
        wait_idle(at);

        // randomized masks, echo shapes and mid-measurement mask changes
        do_reset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NS; i++) begin
                cfg_kind[i]  = ($urandom_range(0, 6) == 0) ? 1 : 0;
                cfg_delay[i] = $urandom_range(0, 40);
                cfg_width[i] = $urandom_range(1, 120);
            end
            sensor_mask = NS'($urandom_range(1, 15));
            enable = 1'b1;
            wait_results($urandom_range(2, 5));
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        enable = 1'b0;
        wait_idle(at);
        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
